cache_fill_arbiter: RTL and testbench

- Sits directly downstream of the instruction and data caches.
- Shares the single multi-cycle memory4c-style main memory between I-cache misses, D-cache misses and D-cache write-through stores.
- On a miss it streams one 8-word (16-byte) block from memory into the requesting cache, supplying a word index and write enable per word, then pulses a done signal so the cache writes its tag and releases its stall.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/fill_word_counter.sv | 37 +++
 rtl/cache_fill_arbiter.sv | 174 +++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache fill arbiter: FSM states, block geometry
// and owner encoding.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL_ISSUE,
    FILL_DRAIN,
    DONE,
    WRITE
  } state_t;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_W        = 3;
  localparam int BLOCK_BASE_MSB  = 15;
  localparam int BLOCK_BASE_LSB  = 4;
  localparam int BASE_W          = BLOCK_BASE_MSB - BLOCK_BASE_LSB + 1;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Byte address of a 16-bit word inside a 16-byte block.
  function automatic logic [15:0] block_word_addr(input logic [BASE_W-1:0]   base,
                                                  input logic [OFFSET_W-1:0] word);
    return {base, word, 1'b0};
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Block word counter with synchronous clear, increment enable and a flag on the
// last word of the block. Wraps from the last word back to 0.
module fill_word_counter
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [OFFSET_W-1:0] cnt,
  output logic                tc
);

  logic [OFFSET_W-1:0] cnt_d;
  logic [OFFSET_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == OFFSET_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one pipelined main memory between I-cache fills, D-cache fills and
// D-cache write-through stores; streams 8-word blocks back into the owning cache.
module cache_fill_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_miss_req,
  input  logic [ADDR_W-1:0]        i_miss_addr,
  input  logic                     d_miss_req,
  input  logic [ADDR_W-1:0]        d_miss_addr,
  input  logic                     d_wr_req,
  input  logic [ADDR_W-1:0]        d_wr_addr,
  input  logic [DATA_W-1:0]        d_wr_data,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_enable,
  output logic                     mem_wr,
  output logic [DATA_W-1:0]        mem_data_in,
  input  logic [DATA_W-1:0]        mem_data_out,
  input  logic                     mem_data_valid,
  output logic [DATA_W-1:0]        fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     i_fill_we,
  output logic                     d_fill_we,
  output logic                     i_fill_done,
  output logic                     d_fill_done,
  output logic                     d_wr_ack,
  output logic                     busy
);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic                i_fill_done_q, i_fill_done_d;
  logic                d_fill_done_q, d_fill_done_d;
  logic                d_wr_ack_q, d_wr_ack_d;

  logic                issue_clr, issue_inc, issue_tc;
  logic                rcv_clr, rcv_inc, rcv_tc;
  logic [OFFSET_W-1:0] issue_cnt, rcv_cnt;
  logic                ret_valid;

  logic                unused_offset_bits;
  assign unused_offset_bits = ^{i_miss_addr[BLOCK_BASE_LSB-1:0], d_miss_addr[BLOCK_BASE_LSB-1:0]};

  fill_word_counter u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (issue_clr),
    .inc (issue_inc),
    .cnt (issue_cnt),
    .tc  (issue_tc)
  );

  fill_word_counter u_rcv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (rcv_clr),
    .inc (rcv_inc),
    .cnt (rcv_cnt),
    .tc  (rcv_tc)
  );

  // Returns are only meaningful while a fill is in flight; anything else is noise.
  assign ret_valid = mem_data_valid && ((state_q == FILL_ISSUE) || (state_q == FILL_DRAIN));
  assign rcv_inc   = ret_valid;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    base_d        = base_q;
    mem_enable_d  = 1'b0;
    mem_wr_d      = 1'b0;
    mem_addr_d    = '0;
    mem_data_in_d = '0;
    i_fill_done_d = 1'b0;
    d_fill_done_d = 1'b0;
    d_wr_ack_d    = 1'b0;
    issue_clr     = 1'b0;
    issue_inc     = 1'b0;
    rcv_clr       = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_wr_req) begin
          state_d       = WRITE;
          mem_enable_d  = 1'b1;
          mem_wr_d      = 1'b1;
          mem_addr_d    = d_wr_addr;
          mem_data_in_d = d_wr_data;
          d_wr_ack_d    = 1'b1;
        end else if (d_miss_req || i_miss_req) begin
          owner_d      = d_miss_req ? OWNER_D : OWNER_I;
          base_d       = d_miss_req ? d_miss_addr[BLOCK_BASE_MSB:BLOCK_BASE_LSB]
                                    : i_miss_addr[BLOCK_BASE_MSB:BLOCK_BASE_LSB];
          issue_clr    = 1'b1;
          rcv_clr      = 1'b1;
          state_d      = FILL_ISSUE;
          mem_enable_d = 1'b1;
          mem_addr_d   = ADDR_W'(block_word_addr(base_d, '0));
        end
      end
      // Outputs are registered, so the next word's address is prepared one cycle ahead.
      FILL_ISSUE: begin
        issue_inc = 1'b1;
        if (issue_tc) begin
          state_d = FILL_DRAIN;
        end else begin
          mem_enable_d = 1'b1;
          mem_addr_d   = ADDR_W'(block_word_addr(base_q, issue_cnt + 1'b1));
        end
      end
      FILL_DRAIN: begin
        if (ret_valid && rcv_tc) begin
          state_d       = DONE;
          i_fill_done_d = (owner_q == OWNER_I);
          d_fill_done_d = (owner_q == OWNER_D);
        end
      end
      DONE:    state_d = IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= OWNER_I;
      base_q        <= '0;
      mem_enable_q  <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      i_fill_done_q <= 1'b0;
      d_fill_done_q <= 1'b0;
      d_wr_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      base_q        <= base_d;
      mem_enable_q  <= mem_enable_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      i_fill_done_q <= i_fill_done_d;
      d_fill_done_q <= d_fill_done_d;
      d_wr_ack_q    <= d_wr_ack_d;
    end
  end

  assign mem_enable  = mem_enable_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign i_fill_done = i_fill_done_q;
  assign d_fill_done = d_fill_done_q;
  assign d_wr_ack    = d_wr_ack_q;
  assign busy        = (state_q != IDLE);

  assign i_fill_we = ret_valid && (owner_q == OWNER_I);
  assign d_fill_we = ret_valid && (owner_q == OWNER_D);
  assign fill_data = ret_valid ? mem_data_out : '0;
  assign fill_word = ret_valid ? rcv_cnt : '0;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Self-checking bench for cache_fill_arbiter: a 4-cycle pipelined memory, a
// transaction-timeline model of the arbiter and directed scenarios.
module tb_cache_fill_arbiter;

  logic        clk;
  logic        rst;
  logic        i_miss_req, d_miss_req, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic [15:0] mem_addr, mem_data_in, mem_data_out, fill_data;
  logic        mem_enable, mem_wr, mem_data_valid;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;

  cache_fill_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_miss_req     (i_miss_req),
    .i_miss_addr    (i_miss_addr),
    .d_miss_req     (d_miss_req),
    .d_miss_addr    (d_miss_addr),
    .d_wr_req       (d_wr_req),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .mem_addr       (mem_addr),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid),
    .fill_data      (fill_data),
    .fill_word      (fill_word),
    .i_fill_we      (i_fill_we),
    .d_fill_we      (d_fill_we),
    .i_fill_done    (i_fill_done),
    .d_fill_done    (d_fill_done),
    .d_wr_ack       (d_wr_ack),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        ack;
    logic        iwe;
    logic        dwe;
    logic [2:0]  word;
    logic [15:0] data;
    logic        idone;
    logic        ddone;
  } out_t;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  localparam int DEPTH = 4096;

  out_t exp_tab [DEPTH];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   free_at = 0;
  ev_t  rd_q[$], wr_q[$], iwe_q[$], dwe_q[$];
  int   idone_cyc, ddone_cyc, ack_cnt, done_cnt, busy_cnt;
  logic busy_log [DEPTH];
  logic i_done_seen, d_done_seen, ack_seen;
  logic spurious;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 + {13'd0, a[3:1]};
  endfunction

  // Memory: every read issued in cycle c returns in cycle c+4; reset flushes it.
  logic        rv;
  logic [15:0] ra;
  logic        pv [4];
  logic [15:0] pd [4];
  initial begin
    mem_data_valid = 1'b0;
    mem_data_out   = 16'h0;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pd[i] = 16'h0;
    end
    forever begin
      @(negedge clk);
      rv = (mem_enable === 1'b1) && (mem_wr === 1'b0);
      ra = mem_addr;
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 4; i++) pv[i] = 1'b0;
      end else begin
        for (int i = 3; i > 0; i--) begin
          pv[i] = pv[i-1];
          pd[i] = pd[i-1];
        end
        pv[0] = rv;
        pd[0] = mem_word(ra);
      end
      #1;
      mem_data_valid = pv[3] | spurious;
      mem_data_out   = pv[3] ? pd[3] : 16'hDEAD;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: an accepted miss owns the next 13 cycles; reads go out in cycles +1..+8,
  // words land in +5..+12, done in +13. A store occupies cycle +1 only.
  task automatic modelStep(input int c);
    logic [15:0] base;
    logic        own_d;
    if (rst) begin
      for (int i = c + 1; i < c + 20; i++) exp_tab[i] = '0;
      free_at = c + 1;
    end else if (c >= free_at) begin
      if (d_wr_req) begin
        exp_tab[c+1].busy = 1'b1;
        exp_tab[c+1].en   = 1'b1;
        exp_tab[c+1].wr   = 1'b1;
        exp_tab[c+1].addr = d_wr_addr;
        exp_tab[c+1].din  = d_wr_data;
        exp_tab[c+1].ack  = 1'b1;
        free_at = c + 2;
      end else if (d_miss_req || i_miss_req) begin
        own_d = d_miss_req;
        base  = own_d ? d_miss_addr : i_miss_addr;
        base[3:0] = 4'h0;
        for (int k = 0; k < 8; k++) begin
          exp_tab[c+1+k].en   = 1'b1;
          exp_tab[c+1+k].addr = base + 16'(2 * k);
          exp_tab[c+5+k].iwe  = !own_d;
          exp_tab[c+5+k].dwe  = own_d;
          exp_tab[c+5+k].word = 3'(k);
          exp_tab[c+5+k].data = mem_word(base + 16'(2 * k));
        end
        for (int j = 1; j <= 13; j++) exp_tab[c+j].busy = 1'b1;
        exp_tab[c+13].idone = !own_d;
        exp_tab[c+13].ddone = own_d;
        free_at = c + 14;
      end
    end
  endtask

  task automatic compareModel(input int c);
    out_t act;
    act       = '0;
    act.busy  = busy;
    act.en    = mem_enable;
    if (mem_enable) begin
      act.wr   = mem_wr;
      act.addr = mem_addr;
      if (mem_wr) act.din = mem_data_in;
    end
    act.ack   = d_wr_ack;
    act.iwe   = i_fill_we;
    act.dwe   = d_fill_we;
    if (i_fill_we || d_fill_we) begin
      act.word = fill_word;
      act.data = fill_data;
    end
    act.idone = i_fill_done;
    act.ddone = d_fill_done;
    checks++;
    if (act !== exp_tab[c]) begin
      errors++;
      $display("[TB] FAIL cycle_model c=%0d: got %h expected %h", c, act, exp_tab[c]);
    end
  endtask

  task automatic logEvents(input int c);
    if (mem_enable && !mem_wr) rd_q.push_back('{cyc: c, a: mem_addr, d: 16'h0});
    if (mem_enable && mem_wr)  wr_q.push_back('{cyc: c, a: mem_addr, d: mem_data_in});
    if (i_fill_we) iwe_q.push_back('{cyc: c, a: 16'(fill_word), d: fill_data});
    if (d_fill_we) dwe_q.push_back('{cyc: c, a: 16'(fill_word), d: fill_data});
    if (i_fill_done) begin idone_cyc = c; done_cnt++; end
    if (d_fill_done) begin ddone_cyc = c; done_cnt++; end
    if (d_wr_ack) ack_cnt++;
    if (busy) busy_cnt++;
    busy_log[c] = busy;
  endtask

  // One clock per iteration: check the cycle, then emulate caches dropping requests.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      compareModel(cyc);
      logEvents(cyc);
      modelStep(cyc);
      i_done_seen = i_fill_done;
      d_done_seen = d_fill_done;
      ack_seen    = d_wr_ack;
      @(posedge clk);
      #2;
      cyc++;
      if (i_done_seen) i_miss_req = 1'b0;
      if (d_done_seen) d_miss_req = 1'b0;
      if (ack_seen)    d_wr_req   = 1'b0;
    end
  endtask

  task automatic waitQuiet(input string name);
    int n;
    n = 0;
    while ((i_miss_req || d_miss_req || d_wr_req || busy) && n < 200) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(name, 32'(n >= 200), 32'd0);
  endtask

  task automatic clearLogs();
    rd_q.delete(); wr_q.delete(); iwe_q.delete(); dwe_q.delete();
    idone_cyc = -1; ddone_cyc = -1; ack_cnt = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"},     32'(busy), 32'd0);
    checkOutput({tag, "_mem_en"},   32'(mem_enable), 32'd0);
    checkOutput({tag, "_mem_wr"},   32'(mem_wr), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_mem_din"},  32'(mem_data_in), 32'd0);
    checkOutput({tag, "_fill"},     {13'd0, fill_word, fill_data}, 32'd0);
    checkOutput({tag, "_strobes"},
                32'({i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    rst = 1'b1; spurious = 1'b0;
    i_miss_req = 1'b0; d_miss_req = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_tab[i]  = '0;
      busy_log[i] = 1'b0;
    end
    clearLogs();
    @(posedge clk);
    #2;
    cyc = 0;
    applyStimulus(3);
    rst = 1'b0;
    checkReset("por");
    applyStimulus(2);

    $display("[TB] I miss at 0x1234");
    clearLogs();
    i_miss_req = 1'b1; i_miss_addr = 16'h1234; a = cyc;
    waitQuiet("t1_quiet");
    checkOutput("t1_reads", rd_q.size(), 8);
    checkOutput("t1_iwe_count", iwe_q.size(), 8);
    if (rd_q.size() == 8 && iwe_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        checkOutput($sformatf("t1_addr%0d", k), 32'(rd_q[k].a), 32'(16'h1230 + 2 * k));
        checkOutput($sformatf("t1_addr_cyc%0d", k), rd_q[k].cyc - a, 1 + k);
        checkOutput($sformatf("t1_word%0d", k), 32'(iwe_q[k].a), k);
        checkOutput($sformatf("t1_data%0d", k), 32'(iwe_q[k].d), 32'(16'hA000 + k));
        checkOutput($sformatf("t1_we_cyc%0d", k), iwe_q[k].cyc - a, 5 + k);
      end
    end
    checkOutput("t1_done_cyc", idone_cyc - a, 13);
    checkOutput("t1_busy_c13", 32'(busy_log[a+13]), 32'd1);
    checkOutput("t1_busy_c14", 32'(busy_log[a+14]), 32'd0);
    checkOutput("t1_no_dwe", dwe_q.size(), 0);
    applyStimulus(2);

    $display("[TB] simultaneous D miss 0x2000 and I miss 0x0040");
    clearLogs();
    d_miss_req = 1'b1; d_miss_addr = 16'h2000;
    i_miss_req = 1'b1; i_miss_addr = 16'h0040; a = cyc;
    waitQuiet("t2_quiet");
    checkOutput("t2_d_done_cyc", ddone_cyc - a, 13);
    checkOutput("t2_i_done_cyc", idone_cyc - a, 27);
    checkOutput("t2_dwe_count", dwe_q.size(), 8);
    checkOutput("t2_iwe_count", iwe_q.size(), 8);
    if (iwe_q.size() == 8 && dwe_q.size() == 8) begin
      checkOutput("t2_first_iwe_cyc", iwe_q[0].cyc - a, 19);
      checkOutput("t2_last_dwe_cyc", dwe_q[7].cyc - a, 12);
    end
    if (rd_q.size() == 16) begin
      checkOutput("t2_d_addr0", 32'(rd_q[0].a), 32'h2000);
      checkOutput("t2_i_addr0", 32'(rd_q[8].a), 32'h0040);
      checkOutput("t2_i_issue_cyc", rd_q[8].cyc - ddone_cyc, 2);
    end
    applyStimulus(2);

    $display("[TB] store 0x0100/0xBEEF with D miss 0x3000");
    clearLogs();
    d_wr_req = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'hBEEF;
    d_miss_req = 1'b1; d_miss_addr = 16'h3000; a = cyc;
    waitQuiet("t3_quiet");
    checkOutput("t3_writes", wr_q.size(), 1);
    checkOutput("t3_ack_count", ack_cnt, 1);
    if (wr_q.size() == 1) begin
      checkOutput("t3_wr_cyc", wr_q[0].cyc - a, 1);
      checkOutput("t3_wr_addr", 32'(wr_q[0].a), 32'h0100);
      checkOutput("t3_wr_data", 32'(wr_q[0].d), 32'hBEEF);
    end
    if (rd_q.size() == 8) begin
      checkOutput("t3_fill_issue_cyc", rd_q[0].cyc - a, 3);
      checkOutput("t3_fill_addr0", 32'(rd_q[0].a), 32'h3000);
    end
    checkOutput("t3_d_done_cyc", ddone_cyc - a, 15);
    checkOutput("t3_no_iwe", iwe_q.size(), 0);
    applyStimulus(2);

    $display("[TB] store arriving during an I fill");
    clearLogs();
    i_miss_req = 1'b1; i_miss_addr = 16'h0500; a = cyc;
    applyStimulus(3);
    d_wr_req = 1'b1; d_wr_addr = 16'h0102; d_wr_data = 16'h1111;
    waitQuiet("t4_quiet");
    checkOutput("t4_i_done_cyc", idone_cyc - a, 13);
    checkOutput("t4_writes", wr_q.size(), 1);
    if (wr_q.size() == 1) begin
      checkOutput("t4_wr_cyc", wr_q[0].cyc - a, 15);
      checkOutput("t4_wr_addr", 32'(wr_q[0].a), 32'h0102);
      checkOutput("t4_wr_data", 32'(wr_q[0].d), 32'h1111);
    end
    applyStimulus(2);

    $display("[TB] reset during the 4th issue cycle");
    clearLogs();
    i_miss_req = 1'b1; i_miss_addr = 16'h0600; a = cyc;
    applyStimulus(4);
    rst = 1'b1; i_miss_req = 1'b0;
    applyStimulus(1);
    rst = 1'b0;
    checkReset("midfill");
    checkOutput("t5_reads_before_reset", rd_q.size(), 4);
    applyStimulus(8);
    checkOutput("t5_no_stale_we", iwe_q.size() + dwe_q.size(), 0);
    checkOutput("t5_no_done", done_cnt, 0);
    clearLogs();
    i_miss_req = 1'b1; i_miss_addr = 16'h0700; a = cyc;
    waitQuiet("t5_quiet");
    checkOutput("t5_iwe_count", iwe_q.size(), 8);
    if (iwe_q.size() == 8) begin
      checkOutput("t5_first_word", 32'(iwe_q[0].a), 0);
      checkOutput("t5_last_word", 32'(iwe_q[7].a), 7);
    end
    if (rd_q.size() == 8) checkOutput("t5_addr0", 32'(rd_q[0].a), 32'h0700);
    checkOutput("t5_done_cyc", idone_cyc - a, 13);
    applyStimulus(2);

    $display("[TB] spurious mem_data_valid while idle");
    clearLogs();
    spurious = 1'b1;
    applyStimulus(4);
    spurious = 1'b0;
    applyStimulus(4);
    checkOutput("t6_no_we", iwe_q.size() + dwe_q.size(), 0);
    checkOutput("t6_no_done", done_cnt, 0);
    checkOutput("t6_never_busy", busy_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
